// File: rtl/sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_scan_ctrl
//   Time-multiplexing scan controller for a 4-digit common-anode seven-segment
//   display. Holds a 16-bit hex value and lights one digit per refresh slot.
//   Each slot starts with a short all-anodes-off gap to suppress ghosting.
//   New values arrive through a valid/ready handshake. They are parked in a
//   one-entry pending register and copied to the display register only at a
//   frame end, so a frame never mixes old and new digits.
//
//   Optional build macro: SSEG_LZB_EN (leading-zero blanking). When it is
//   defined, digits above the most significant non-zero nibble keep their anode
//   enabled but drive all segments off. Digit 0 is always shown.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   BLANK_CYC    blank cycles at the start of each slot (1 <= BLANK_CYC < REFRESH_DIV)
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   upd_valid     in   upd_value is offered
//   upd_value     in   [15:12]=digit3 .. [3:0]=digit0
//   upd_ready     out  pending slot empty; accept on valid && ready
//   sseg_anode    out  active-low digit enables, bit i = digit i
//   sseg_cathode  out  active-low segments {g,f,e,d,c,b,a}
//   frame_tick    out  one-cycle pulse on the last cycle of slot 3
// -----------------------------------------------------------------------------
module sseg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_valid,
    input  logic [15:0] upd_value,
    output logic        upd_ready,
    output logic [3:0]  sseg_anode,
    output logic [6:0]  sseg_cathode,
    output logic        frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    cathode_q, cathode_d;

    logic          frame_end;
    logic          accept;
    logic [3:0]    nibble;
    logic          digit_dark;

    // Hex-to-segment decode; A..F share a single error glyph.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0011000;
            default: s = 7'b1001001;
        endcase
        return s;
    endfunction

`ifdef SSEG_LZB_EN
    // Index of the most significant non-zero nibble; 0 when the value is 0,
    // which keeps digit 0 lit.
    function automatic logic [1:0] msd_index(input logic [15:0] v);
        logic [1:0] idx;
        if (v[15:12] != 4'h0)     idx = 2'd3;
        else if (v[11:8] != 4'h0) idx = 2'd2;
        else if (v[7:4] != 4'h0)  idx = 2'd1;
        else                      idx = 2'd0;
        return idx;
    endfunction
`endif

    assign frame_end = (presc_q == PRESC_LAST) && (dig_q == 2'd3);
    assign accept    = upd_valid && !pend_full_q;

    always_comb begin
        presc_d     = presc_q + PW'(1);
        dig_d       = dig_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;

        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            dig_d   = dig_q + 2'd1;
        end

        // The frame-end copy only happens when something was pending before
        // this cycle, so a same-cycle accept waits for the next frame.
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = upd_value;
            pend_full_d = 1'b1;
        end

        // Outputs are computed from next-state so the registered pins line up
        // with presc/dig: blanking starts on the very first cycle of a slot.
        nibble = disp_d[4*dig_d +: 4];
`ifdef SSEG_LZB_EN
        digit_dark = (dig_d > msd_index(disp_d));
`else
        digit_dark = 1'b0;
`endif
        if (presc_d < BLANK_END) begin
            anode_d   = 4'b1111;
            cathode_d = 7'b1111111;
        end else begin
            anode_d   = ~(4'b0001 << dig_d);
            cathode_d = digit_dark ? 7'b1111111 : seg_decode(nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            dig_q       <= 2'd0;
            disp_q      <= 16'h0000;
            pend_q      <= 16'h0000;
            pend_full_q <= 1'b0;
            anode_q     <= 4'b1111;
            cathode_q   <= 7'b1111111;
        end else begin
            presc_q     <= presc_d;
            dig_q       <= dig_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            anode_q     <= anode_d;
            cathode_q   <= cathode_d;
        end
    end

    assign upd_ready    = ~pend_full_q;
    assign sseg_anode   = anode_q;
    assign sseg_cathode = cathode_q;
    assign frame_tick   = frame_end;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_ctrl
//   Directed bench for sseg_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2.
//   A cycle counter (cyc, reset to 0 in the first cycle after the reset edge)
//   gives the expected slot position; exp_disp holds the value that should be
//   on the display, updated by hand at the frame ends where it must change.
// -----------------------------------------------------------------------------
module tb_sseg_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_value = 16'h0000;
    logic        upd_ready;
    logic [3:0]  sseg_anode;
    logic [6:0]  sseg_cathode;
    logic        frame_tick;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [15:0] exp_disp = 16'h0000;

    sseg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk          (clk),
        .rst          (rst),
        .upd_valid    (upd_valid),
        .upd_value    (upd_value),
        .upd_ready    (upd_ready),
        .sseg_anode   (sseg_anode),
        .sseg_cathode (sseg_cathode),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0011000;
            default: return 7'b1001001;
        endcase
    endfunction

    function automatic logic [3:0] exp_anode(input int c);
        int p;
        int d;
        p = c % RD;
        d = (c / RD) % 4;
        if (p < BC) return 4'b1111;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [6:0] exp_cath(input int c, input logic [15:0] v);
        int p;
        int d;
        int msd;
        p = c % RD;
        d = (c / RD) % 4;
        if (p < BC) return 7'b1111111;
`ifdef SSEG_LZB_EN
        msd = 0;
        for (int k = 1; k < 4; k++)
            if (v[4*k +: 4] != 4'h0) msd = k;
        if (d > msd) return 7'b1111111;
`else
        msd = 0;
`endif
        return seg_of(v[4*d +: 4]);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Check the scan outputs of the current cycle against the model.
    task automatic check_cycle();
        chk("anode",   {12'h000, sseg_anode},   {12'h000, exp_anode(cyc)});
        chk("cathode", {9'h000, sseg_cathode},  {9'h000, exp_cath(cyc, exp_disp)});
        chk("tick",    {15'h0000, frame_tick},  {15'h0000, (cyc % (4*RD)) == (4*RD - 1)});
    endtask

    task automatic adv();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            check_cycle();
            adv();
        end
    endtask

    initial begin
        // Reset edge, then check the post-reset state.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        chk("rst_anode",   {12'h000, sseg_anode},  16'h000F);
        chk("rst_cathode", {9'h000, sseg_cathode}, 16'h007F);
        chk("rst_ready",   {15'h0000, upd_ready},  16'h0001);
        chk("rst_tick",    {15'h0000, frame_tick}, 16'h0000);

        // Idle scan of a blank-value display, then accept 9A05 mid-frame.
        run(35);
        chk("ready_before_9A05", {15'h0000, upd_ready}, 16'h0001);
        upd_valid = 1'b1;
        upd_value = 16'h9A05;
        check_cycle();
        adv();
        upd_valid = 1'b0;
        upd_value = 16'h0000;
        repeat (28) begin
            chk("ready_pend_9A05", {15'h0000, upd_ready}, 16'h0000);
            check_cycle();
            adv();
        end
        exp_disp = 16'h9A05;
        chk("ready_after_frame", {15'h0000, upd_ready}, 16'h0001);
        run(31);

        // Accept 1234 on the exact frame-end cycle: old value held a frame.
        upd_valid = 1'b1;
        upd_value = 16'h1234;
        check_cycle();
        adv();
        upd_valid = 1'b0;
        chk("ready_pend_1234", {15'h0000, upd_ready}, 16'h0000);
        run(4);

        // Second offer while full is ignored until the frame end.
        upd_valid = 1'b1;
        upd_value = 16'h5678;
        repeat (28) begin
            chk("ready_full_5678", {15'h0000, upd_ready}, 16'h0000);
            check_cycle();
            adv();
        end
        exp_disp = 16'h1234;
        chk("ready_reopen", {15'h0000, upd_ready}, 16'h0001);
        check_cycle();
        adv();
        upd_valid = 1'b0;
        upd_value = 16'h0000;
        chk("ready_pend_5678", {15'h0000, upd_ready}, 16'h0000);
        run(31);
        exp_disp = 16'h5678;
        run(32);

        // Queue FFFF, then reset in the middle of slot 2.
        chk("ready_before_FFFF", {15'h0000, upd_ready}, 16'h0001);
        upd_valid = 1'b1;
        upd_value = 16'hFFFF;
        check_cycle();
        adv();
        upd_valid = 1'b0;
        chk("ready_pend_FFFF", {15'h0000, upd_ready}, 16'h0000);
        run(18);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        exp_disp = 16'h0000;
        chk("mid_rst_anode",   {12'h000, sseg_anode},  16'h000F);
        chk("mid_rst_cathode", {9'h000, sseg_cathode}, 16'h007F);
        chk("mid_rst_ready",   {15'h0000, upd_ready},  16'h0001);
        chk("mid_rst_tick",    {15'h0000, frame_tick}, 16'h0000);
        run(72);
        chk("ready_after_rst", {15'h0000, upd_ready}, 16'h0001);

        // Value with leading zeros (blanked only in the SSEG_LZB_EN build).
        upd_valid = 1'b1;
        upd_value = 16'h0030;
        check_cycle();
        adv();
        upd_valid = 1'b0;
        run(23);
        exp_disp = 16'h0030;
        run(32);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
